// File: rtl/camera_st_pkg.sv
// Shared types and helpers for the camera Avalon-ST source.
// Holds the FIFO entry layout, write-FSM states and RGB565->RGB30 expansion.
package camera_st_pkg;
    localparam int PIX565_W  = 16;
    localparam int ST_DATA_W = 30;

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic [ST_DATA_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} wr_state_t;

    // Replicate MSBs into the new LSBs so full-scale stays full-scale.
    function automatic logic [ST_DATA_W-1:0] rgb565_to_rgb30(input logic [PIX565_W-1:0] p);
        return {p[15:11], p[15:11], p[10:5], p[10:7], p[4:0], p[4:0]};
    endfunction
endpackage

// File: rtl/st_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head register.
// count covers the head register plus the backing memory.
module st_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] mcount;
    logic          pop;
    logic          load;

    assign pop   = rd_valid & rd_ready;
    // Head reloads only when it is empty or being consumed, so it holds under backpressure.
    assign load  = (mcount != '0) & (~rd_valid | pop);
    assign count = mcount + CW'(rd_valid);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mcount   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_en, load})
                2'b10:   mcount <= mcount + CW'(1);
                2'b01:   mcount <= mcount - CW'(1);
                default: mcount <= mcount;
            endcase
            if (load)     rd_valid <= 1'b1;
            else if (pop) rd_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/camera_st_source.sv
// Camera capture to Avalon-ST video source: RGB565 -> RGB30, one packet per frame,
// FIFO-buffered for sink backpressure, with abort/filler handling on overflow or short frames.
module camera_st_source
    import camera_st_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    input  logic [PIX565_W-1:0]  pix_data,
    input  logic                 src_ready,
    output logic                 src_valid,
    output logic [ST_DATA_W-1:0] src_data,
    output logic                 src_startofpacket,
    output logic                 src_endofpacket,
    output logic                 frame_dropped,
    input  logic                 clr_status,
    output logic [15:0]          frames_sent
);
    localparam int FRAME_PIX = WIDTH * HEIGHT;
    localparam int PCW       = $clog2(FRAME_PIX + 1);
    localparam int FCW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [PCW-1:0] LAST_IDX = PCW'(FRAME_PIX - 1);
    localparam logic [FCW-1:0] FULL_LVL = FCW'(FIFO_DEPTH - 1);

    wr_state_t   state, state_d;
    logic [PCW-1:0] cnt, cnt_d;
    fifo_entry_t wr_entry;
    fifo_entry_t head;
    logic        wr_en;
    logic        drop_set;
    logic        full;
    logic [FCW-1:0] fifo_count;

    // Threshold one below capacity keeps a slot free for the abort filler beat.
    assign full = fifo_count >= FULL_LVL;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        wr_en         = 1'b0;
        drop_set      = 1'b0;
        wr_entry.sop  = 1'b0;
        wr_entry.eop  = 1'b0;
        wr_entry.data = rgb565_to_rgb30(pix_data);
        case (state)
            IDLE: begin
                if (pix_valid && pix_sof) begin
                    // A full FIFO here would leave no room for a filler, so lose the frame up front.
                    if (full) begin
                        drop_set = 1'b1;
                    end else begin
                        wr_en        = 1'b1;
                        wr_entry.sop = 1'b1;
                        if (FRAME_PIX == 1) begin
                            wr_entry.eop = 1'b1;
                        end else begin
                            state_d = ACTIVE;
                            cnt_d   = PCW'(1);
                        end
                    end
                end
            end
            ACTIVE: begin
                if (pix_valid) begin
                    if (pix_sof || full) begin
                        state_d = ABORT;
                    end else begin
                        wr_en = 1'b1;
                        if (cnt == LAST_IDX) begin
                            wr_entry.eop = 1'b1;
                            state_d      = IDLE;
                            cnt_d        = '0;
                        end else begin
                            cnt_d = cnt + PCW'(1);
                        end
                    end
                end
            end
            ABORT: begin
                wr_en         = 1'b1;
                wr_entry.data = '0;
                wr_entry.eop  = 1'b1;
                drop_set      = 1'b1;
                state_d       = IDLE;
                cnt_d         = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    st_sync_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_entry),
        .rd_ready (src_ready),
        .rd_valid (src_valid),
        .rd_data  (head),
        .count    (fifo_count)
    );

    assign src_data          = head.data;
    assign src_startofpacket = head.sop;
    assign src_endofpacket   = head.eop;

    // Set beats clear for frame_dropped; clear beats increment for frames_sent.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frame_dropped <= 1'b0;
            frames_sent   <= '0;
        end else begin
            if (drop_set)        frame_dropped <= 1'b1;
            else if (clr_status) frame_dropped <= 1'b0;
            if (clr_status)
                frames_sent <= '0;
            else if (src_valid && src_ready && head.eop)
                frames_sent <= frames_sent + 16'd1;
        end
    end
endmodule

// File: tb/tb_camera_st_source.sv
// Directed bench for camera_st_source (4x2 frame, 4-entry FIFO): table-driven frames
// plus hand-written overflow, short-frame, reset and status sequences.
module tb_camera_st_source;
    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [15:0] pix_data = '0;
    logic        src_ready = 1'b1;
    logic        src_valid;
    logic [29:0] src_data;
    logic        src_startofpacket;
    logic        src_endofpacket;
    logic        frame_dropped;
    logic        clr_status = 1'b0;
    logic [15:0] frames_sent;

    always #5 clk_clk = ~clk_clk;

    camera_st_source #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .pix_valid         (pix_valid),
        .pix_sof           (pix_sof),
        .pix_data          (pix_data),
        .src_ready         (src_ready),
        .src_valid         (src_valid),
        .src_data          (src_data),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
        .frame_dropped     (frame_dropped),
        .clr_status        (clr_status),
        .frames_sent       (frames_sent)
    );

    typedef struct {
        logic [15:0] pix;
        logic [29:0] data;
        logic        sop;
        logic        eop;
    } vec_t;

    vec_t        vt [16];
    int          total = 0;
    int          bad = 0;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    bit          bp_en = 1'b0;
    int          bp_phase = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_beat = '0;
    logic [31:0] beat;

    assign beat = {src_startofpacket, src_endofpacket, 30'(src_data)};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] eb(input logic sop, input logic eop, input logic [29:0] d);
        return {sop, eop, d};
    endfunction

    // Sink monitor: collect transferred beats and check stability while stalled.
    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(src_valid), 32'd1);
                check("hold_beat", beat, stall_beat);
            end
            if (src_valid && src_ready) got_q.push_back(beat);
            stall_prev = src_valid && !src_ready;
            stall_beat = beat;
        end
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
        if (bp_en) begin
            src_ready = (bp_phase % 4 == 0) || (bp_phase % 4 == 3);
            bp_phase++;
        end
    endtask

    task automatic pix(input logic [15:0] d, input logic sof);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < 8; i++) exp_q.push_back(eb(vt[base+i].sop, vt[base+i].eop, vt[base+i].data));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({name, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{16'hF800, 30'h3FF00000, 1'b1, 1'b0};
        vt[1]  = '{16'hF801, 30'h3FF00021, 1'b0, 1'b0};
        vt[2]  = '{16'hF802, 30'h3FF00042, 1'b0, 1'b0};
        vt[3]  = '{16'hF803, 30'h3FF00063, 1'b0, 1'b0};
        vt[4]  = '{16'hF804, 30'h3FF00084, 1'b0, 1'b0};
        vt[5]  = '{16'hF805, 30'h3FF000A5, 1'b0, 1'b0};
        vt[6]  = '{16'hF806, 30'h3FF000C6, 1'b0, 1'b0};
        vt[7]  = '{16'hF807, 30'h3FF000E7, 1'b0, 1'b1};
        vt[8]  = '{16'hFFFF, 30'h3FFFFFFF, 1'b1, 1'b0};
        vt[9]  = '{16'h0000, 30'h00000000, 1'b0, 1'b0};
        vt[10] = '{16'h07E0, 30'h000FFC00, 1'b0, 1'b0};
        vt[11] = '{16'h001F, 30'h000003FF, 1'b0, 1'b0};
        vt[12] = '{16'h0020, 30'h00004000, 1'b0, 1'b0};
        vt[13] = '{16'h0800, 30'h02100000, 1'b0, 1'b0};
        vt[14] = '{16'h8410, 30'h21082210, 1'b0, 1'b0};
        vt[15] = '{16'h0841, 30'h02108021, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_valid", 32'(src_valid), 32'd0);
        check("rst_beat", beat, 32'd0);
        check("rst_dropped", 32'(frame_dropped), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        tick();

        // Two full frames from the table, sink always ready
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                pix(vt[f*8+i].pix, i == 0);
                if (f == 0 && i == 0) check("lat_e0_valid", 32'(src_valid), 32'd0);
                if (f == 0 && i == 1) begin
                    check("lat_e1_valid", 32'(src_valid), 32'd1);
                    check("lat_e1_beat", beat, eb(1'b1, 1'b0, 30'h3FF00000));
                end
            end
            push_frame(f * 8);
            drain($sformatf("frame%0d", f));
            check("frames_sent_full", 32'(frames_sent), 32'(f + 1));
            check("dropped_full", 32'(frame_dropped), 32'd0);
        end

        // Status clear
        pulse_clr();
        check("clr_frames", 32'(frames_sent), 32'd0);
        check("clr_dropped", 32'(frame_dropped), 32'd0);

        // Backpressure 1-0-0-1 with a pixel every second cycle
        bp_en = 1'b1;
        bp_phase = 0;
        for (int i = 0; i < 8; i++) begin
            pix(vt[i].pix, i == 0);
            tick();
        end
        push_frame(0);
        drain("bp");
        bp_en = 1'b0;
        src_ready = 1'b1;
        check("bp_frames", 32'(frames_sent), 32'd1);
        check("bp_dropped", 32'(frame_dropped), 32'd0);

        // Overflow: sink stalled, five pixels offered
        src_ready = 1'b0;
        for (int i = 0; i < 5; i++) pix(vt[i].pix, i == 0);
        tick();
        check("ovf_dropped", 32'(frame_dropped), 32'd1);
        check("ovf_head_valid", 32'(src_valid), 32'd1);
        check("ovf_head_beat", beat, eb(1'b1, 1'b0, vt[0].data));
        src_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(eb(vt[i].sop, vt[i].eop, vt[i].data));
        exp_q.push_back(eb(1'b0, 1'b1, 30'h0));
        drain("ovf");
        check("ovf_frames", 32'(frames_sent), 32'd2);

        // Short frame followed by a clean frame
        pulse_clr();
        check("short_pre_dropped", 32'(frame_dropped), 32'd0);
        for (int i = 0; i < 3; i++) pix(vt[8+i].pix, i == 0);
        pix(vt[11].pix, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) pix(vt[i].pix, i == 0);
        for (int i = 0; i < 3; i++) exp_q.push_back(eb(vt[8+i].sop, vt[8+i].eop, vt[8+i].data));
        exp_q.push_back(eb(1'b0, 1'b1, 30'h0));
        push_frame(0);
        drain("short");
        check("short_dropped", 32'(frame_dropped), 32'd1);
        check("short_frames", 32'(frames_sent), 32'd2);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) pix(vt[i].pix, i == 0);
        #3;
        reset_reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(src_valid), 32'd0);
        check("arst_frames", 32'(frames_sent), 32'd0);
        check("arst_dropped", 32'(frame_dropped), 32'd0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        got_q.delete();
        tick();
        tick();
        check("arst_empty", 32'(src_valid), 32'd0);
        pix(vt[2].pix, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) pix(vt[8+i].pix, i == 0);
        push_frame(8);
        drain("arst");
        check("arst_frames_after", 32'(frames_sent), 32'd1);

        // clr_status coincident with the abort cycle: set wins
        src_ready = 1'b0;
        for (int i = 0; i < 4; i++) pix(vt[i].pix, i == 0);
        clr_status = 1'b1;
        pix(vt[4].pix, 1'b0);
        clr_status = 1'b0;
        check("clrset_dropped", 32'(frame_dropped), 32'd1);
        check("clrset_frames", 32'(frames_sent), 32'd0);
        src_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(eb(vt[i].sop, vt[i].eop, vt[i].data));
        exp_q.push_back(eb(1'b0, 1'b1, 30'h0));
        drain("clrset");
        check("clrset_frames_after", 32'(frames_sent), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
